// File: rtl/fixed_point_pkg.sv
// Shared sign-magnitude fixed-point definitions.
// Used by the FFT adder, subtractor and butterfly.
package fixed_point_pkg;

    localparam int FP_WIDTH = 16;
    localparam int FP_MAG_W = FP_WIDTH - 1;

    typedef struct packed {
        logic                sign;
        logic [FP_MAG_W-1:0] mag;
    } fp_t;

    localparam fp_t FP_ZERO = '{sign: 1'b0, mag: '0};

endpackage

// File: rtl/fixed_point_sub_pipe_if.sv
// Valid/ready operand and result bundle for the
// pipelined sign-magnitude subtractor.
interface fixed_point_sub_pipe_if
    import fixed_point_pkg::*;
#(
    parameter int WIDTH = FP_WIDTH
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] c;
    logic             overflow;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, c, overflow
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, c, overflow
    );
endinterface

// File: rtl/fixed_point_sub_pipe_sm_mag_core.sv
// Combinational sign-magnitude add/subtract core.
// Operand signs arrive already adjusted for the operation.
module sm_mag_core #(
    parameter int MAG_W = 15
) (
    input  logic             sa_i,
    input  logic             sb_i,
    input  logic [MAG_W-1:0] ma_i,
    input  logic [MAG_W-1:0] mb_i,
    input  logic             same_i,
    input  logic             agtb_i,
    output logic [MAG_W:0]   word_o,
    output logic             carry_o
);
    logic [MAG_W:0]   sum;
    logic [MAG_W-1:0] mag;
    logic             sign;

    // Pick add or magnitude subtract, then force +0 for a zero result.
    always_comb begin
        sum     = {1'b0, ma_i} + {1'b0, mb_i};
        mag     = '0;
        sign    = 1'b0;
        carry_o = 1'b0;
        if (same_i) begin
            mag     = sum[MAG_W-1:0];
            carry_o = sum[MAG_W];
            sign    = sa_i;
        end else if (agtb_i) begin
            mag  = ma_i - mb_i;
            sign = sa_i;
        end else begin
            mag  = mb_i - ma_i;
            sign = sb_i;
        end
        if (mag == '0) begin
            sign = 1'b0;
        end
        word_o = {sign, mag};
    end
endmodule

// File: rtl/fixed_point_sub_pipe.sv
// Two-stage pipelined sign-magnitude subtractor c = a - b.
// Feeds the difference leg of the radix-2 butterfly.
module fixed_point_sub_pipe
    import fixed_point_pkg::*;
#(
    parameter int WIDTH = FP_WIDTH
) (
    input logic                   clk,
    input logic                   rst,
    fixed_point_sub_pipe_if.slave bus
);
    localparam int MAG_W = WIDTH - 1;

    logic             s1_valid_q, s1_valid_d;
    logic             sa_q, sb_q;
    logic [MAG_W-1:0] ma_q, mb_q;
    logic             same_q, agtb_q;

    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] c_q;
    logic             ovf_q;

    logic             s2_load;
    logic             in_fire;
    logic             sa_d, sb_d;
    logic [MAG_W-1:0] ma_d, mb_d;
    logic [WIDTH-1:0] word;
    logic             carry;

    // Handshake and stage-advance control.
    always_comb begin
        s2_load     = s1_valid_q && (!s2_valid_q || bus.out_ready);
        bus.in_ready = !s1_valid_q || s2_load;
        in_fire     = bus.in_valid && bus.in_ready;
        s1_valid_d  = in_fire ? 1'b1 : (s2_load ? 1'b0 : s1_valid_q);
        s2_valid_d  = s2_load ? 1'b1 : (bus.out_ready ? 1'b0 : s2_valid_q);
        sa_d        = bus.a[WIDTH-1];
        sb_d        = ~bus.b[WIDTH-1];
        ma_d        = bus.a[MAG_W-1:0];
        mb_d        = bus.b[MAG_W-1:0];
    end

    // Stage 1: split operands, negate subtrahend sign, pre-compare.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            sa_q       <= 1'b0;
            sb_q       <= 1'b0;
            ma_q       <= '0;
            mb_q       <= '0;
            same_q     <= 1'b0;
            agtb_q     <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (in_fire) begin
                sa_q   <= sa_d;
                sb_q   <= sb_d;
                ma_q   <= ma_d;
                mb_q   <= mb_d;
                same_q <= (sa_d == sb_d);
                agtb_q <= (ma_d > mb_d);
            end
        end
    end

    sm_mag_core #(
        .MAG_W (MAG_W)
    ) u_core (
        .sa_i    (sa_q),
        .sb_i    (sb_q),
        .ma_i    (ma_q),
        .mb_i    (mb_q),
        .same_i  (same_q),
        .agtb_i  (agtb_q),
        .word_o  (word),
        .carry_o (carry)
    );

    // Stage 2: register the result; hold it while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            c_q        <= '0;
            ovf_q      <= 1'b0;
        end else begin
            s2_valid_q <= s2_valid_d;
            if (s2_load) begin
                c_q   <= word;
                ovf_q <= carry;
            end
        end
    end

    assign bus.out_valid = s2_valid_q;
    assign bus.c         = c_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_fixed_point_sub_pipe.sv
// Directed self-checking bench for fixed_point_sub_pipe.
// Expected values are hand-computed sign-magnitude differences.
module tb_fixed_point_sub_pipe;
    logic clk;
    logic rst;

    int errors;
    int checks;

    fixed_point_sub_pipe_if #(.WIDTH(16)) bus ();

    fixed_point_sub_pipe #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] ta [8];
    logic [15:0] tb_ [8];
    logic [15:0] tc [8];
    logic        to [8];

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag,
                          input logic [15:0] a,
                          input logic [15:0] b,
                          input logic [15:0] exp_c,
                          input logic exp_o);
        int n;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.a         = a;
        bus.b         = b;
        #1;
        chk({tag, "_rdy"}, {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        n = 1;
        while (!bus.out_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_lat"}, n, 32'd2);
        chk({tag, "_c"}, {16'd0, bus.c}, {16'd0, exp_c});
        chk({tag, "_ovf"}, {31'd0, bus.overflow}, {31'd0, exp_o});
        @(posedge clk);
        #1;
    endtask

    task automatic run_stream(input string tag,
                              input int n,
                              input int st0,
                              input int stl,
                              output int drops,
                              output int acc_drop,
                              output int first,
                              output int last,
                              output int unstable);
        int ii;
        int oi;
        int cyc;
        logic [15:0] held;
        logic held_v;
        ii = 0; oi = 0; cyc = 0;
        drops = 0; acc_drop = -1;
        first = -1; last = -1; unstable = 0;
        held = '0; held_v = 1'b0;
        while (oi < n && cyc < 200) begin
            bus.out_ready = !(cyc >= st0 && cyc < st0 + stl);
            bus.in_valid  = (ii < n);
            if (ii < n) begin
                bus.a = ta[ii];
                bus.b = tb_[ii];
            end
            #1;
            if (bus.in_valid && !bus.in_ready) begin
                drops++;
                if (acc_drop < 0) acc_drop = ii;
            end
            if (bus.out_valid && held_v && bus.c !== held) unstable++;
            if (bus.out_valid && bus.out_ready) begin
                chk($sformatf("%s_c%0d", tag, oi),
                    {16'd0, bus.c}, {16'd0, tc[oi]});
                chk($sformatf("%s_o%0d", tag, oi),
                    {31'd0, bus.overflow}, {31'd0, to[oi]});
                if (first < 0) first = cyc;
                last = cyc;
                oi++;
                held_v = 1'b0;
            end else if (bus.out_valid) begin
                held   = bus.c;
                held_v = 1'b1;
            end
            if (bus.in_valid && bus.in_ready) ii++;
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        chk({tag, "_count"}, oi, n);
    endtask

    initial begin
        int drops, acc_drop, first, last, unstable;
        errors = 0;
        checks = 0;

        ta  = '{16'h0010, 16'h0001, 16'h8002, 16'h8010,
                16'h0100, 16'h4000, 16'h8003, 16'h0000};
        tb_ = '{16'h0001, 16'h0010, 16'h8002, 16'h0005,
                16'h80FF, 16'hC000, 16'h8005, 16'h0000};
        tc  = '{16'h000F, 16'h800F, 16'h0000, 16'h8015,
                16'h01FF, 16'h0000, 16'h0002, 16'h0000};
        to  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.a = '0;
        bus.b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ovalid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_c", {16'd0, bus.c}, 32'd0);
        chk("rst_ovf", {31'd0, bus.overflow}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op("pp", 16'h0005, 16'h0003, 16'h0002, 1'b0);
        run_op("pp_rev", 16'h0003, 16'h0005, 16'h8002, 1'b0);
        run_op("mix_na", 16'h8004, 16'h0003, 16'h8007, 1'b0);
        run_op("mix_nb", 16'h0004, 16'h8003, 16'h0007, 1'b0);
        run_op("ovf", 16'h7FFF, 16'h8001, 16'h0000, 1'b1);
        run_op("zero", 16'h0005, 16'h0005, 16'h0000, 1'b0);
        run_op("negz", 16'h8000, 16'h0000, 16'h0000, 1'b0);

        run_stream("strm", 8, 0, 0, drops, acc_drop, first, last, unstable);
        chk("strm_drops", drops, 32'd0);
        chk("strm_first", first, 32'd2);
        chk("strm_span", last - first, 32'd7);

        run_stream("bp", 4, 0, 5, drops, acc_drop, first, last, unstable);
        chk("bp_stalled", {31'd0, drops > 0}, 32'd1);
        chk("bp_acc", acc_drop, 32'd2);
        chk("bp_stable", unstable, 32'd0);

        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.a = 16'h0005;
        bus.b = 16'h0003;
        @(posedge clk);
        #1;
        bus.a = 16'h0004;
        bus.b = 16'h8003;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("mid_full", {31'd0, bus.out_valid}, 32'd1);
        chk("mid_c_pre", {16'd0, bus.c}, 32'h0002);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_ovalid", {31'd0, bus.out_valid}, 32'd0);
        chk("mid_rst_c", {16'd0, bus.c}, 32'd0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_empty", {31'd0, bus.out_valid}, 32'd0);
        run_op("post_rst", 16'h8004, 16'h8001, 16'h8003, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
